// File: rtl/arbitro_mante.sv
// Round-robin arbiter that time-shares one increment-on-enable register among
// N_REQ requesters: grant, load, capture the incremented value, acknowledge.
module arbitro_mante #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       ack,
    output logic [WIDTH-1:0]       resp_data,
    output logic [ID_W-1:0]        grant_id,
    output logic                   busy,
    output logic [WIDTH-1:0]       reg_data_in,
    output logic                   reg_enable,
    input  logic [WIDTH-1:0]       reg_data_out
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t           state;
    logic [ID_W-1:0]  last_grant;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] req_arr [N_REQ];
    logic [ID_W-1:0]  winner;
    logic [ID_W-1:0]  rr_idx;
    logic             found;

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign req_arr[i] = req_data[i*WIDTH +: WIDTH];
    end

    // Search upward from last_grant+1 with wrap, so the last winner ranks lowest.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        rr_idx = last_grant;
        for (int k = 0; k < N_REQ; k++) begin
            rr_idx = (rr_idx == ID_W'(N_REQ - 1)) ? '0 : rr_idx + 1'b1;
            if (!found && req[rr_idx]) begin
                winner = rr_idx;
                found  = 1'b1;
            end
        end
    end

    assign reg_data_in = data_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            ack        <= '0;
            resp_data  <= '0;
            grant_id   <= '0;
            data_q     <= '0;
            reg_enable <= 1'b0;
            busy       <= 1'b0;
            last_grant <= ID_W'(N_REQ - 1);
        end else begin
            ack <= '0;
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        grant_id   <= winner;
                        data_q     <= req_arr[winner];
                        reg_enable <= 1'b1;
                        busy       <= 1'b1;
                        state      <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    reg_enable <= 1'b0;
                    state      <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Register was written at the end of LOAD; its output is valid now.
                    resp_data <= reg_data_out;
                    ack       <= {{(N_REQ-1){1'b0}}, 1'b1} << grant_id;
                    state     <= ST_DONE;
                end
                ST_DONE: begin
                    last_grant <= grant_id;
                    busy       <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: begin
                    reg_enable <= 1'b0;
                    busy       <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arbitro_mante.sv
// Directed bench for arbitro_mante with a behavioural increment register attached.
module tb_arbitro_mante;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic [7:0]  resp_data;
    logic [1:0]  grant_id;
    logic        busy;
    logic [7:0]  reg_data_in;
    logic        reg_enable;
    logic [7:0]  reg_data_out;

    int n_tests = 0;
    int n_fail  = 0;

    arbitro_mante #(.N_REQ(4), .WIDTH(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .req_data     (req_data),
        .ack          (ack),
        .resp_data    (resp_data),
        .grant_id     (grant_id),
        .busy         (busy),
        .reg_data_in  (reg_data_in),
        .reg_enable   (reg_enable),
        .reg_data_out (reg_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared maintenance register: on enable, q <= d + 1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            reg_data_out <= 8'h00;
        else if (reg_enable)
            reg_data_out <= reg_data_in + 8'd1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] exp_g [5];
    logic [7:0] exp_r [5];

    initial begin
        exp_g = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_r = '{8'h11, 8'h21, 8'h31, 8'h41, 8'h11};

        reset    = 1'b0;
        req      = 4'b0000;
        req_data = 32'h0;
        tick();
        tick();
        check("rst_ack", ack, 4'b0000);
        check("rst_busy", busy, 1'b0);
        check("rst_resp", resp_data, 8'h00);
        check("rst_grant", grant_id, 2'd0);
        check("rst_en", reg_enable, 1'b0);
        check("rst_din", reg_data_in, 8'h00);

        reset = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check("idle_busy", busy, 1'b0);
        check("idle_en", reg_enable, 1'b0);

        // Single request from requester 2
        req = 4'b0100;
        req_data[16 +: 8] = 8'h41;
        tick();
        check("single_en_c1", reg_enable, 1'b1);
        check("single_din_c1", reg_data_in, 8'h41);
        check("single_busy_c1", busy, 1'b1);
        tick();
        check("single_en_c2", reg_enable, 1'b0);
        check("single_ack_c2", ack, 4'b0000);
        tick();
        check("single_ack", ack, 4'b0100);
        check("single_resp", resp_data, 8'h42);
        check("single_grant", grant_id, 2'd2);
        req = 4'b0000;
        tick();
        check("single_ack_off", ack, 4'b0000);
        check("single_busy_off", busy, 1'b0);
        check("single_resp_hold", resp_data, 8'h42);

        // Fairness from a fresh reset
        reset = 1'b0;
        #1;
        reset = 1'b1;
        req_data = {8'h40, 8'h30, 8'h20, 8'h10};
        req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            tick();
            check("rr_grant_load", grant_id, exp_g[t]);
            tick();
            tick();
            check("rr_ack", ack, 4'b0001 << exp_g[t]);
            check("rr_resp", resp_data, exp_r[t]);
            tick();
            check("rr_ack_off", ack, 4'b0000);
        end
        req = 4'b0000;

        // Wrap-around result from requester 1
        req_data[8 +: 8] = 8'hFF;
        req = 4'b0010;
        tick();
        tick();
        tick();
        check("wrap_ack", ack, 4'b0010);
        check("wrap_resp", resp_data, 8'h00);
        req = 4'b0000;
        tick();

        // Abort during WAIT
        req_data[24 +: 8] = 8'h77;
        req = 4'b1000;
        tick();
        tick();
        check("abort_in_wait_busy", busy, 1'b1);
        reset = 1'b0;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_ack", ack, 4'b0000);
        check("abort_en", reg_enable, 1'b0);
        check("abort_grant", grant_id, 2'd0);
        check("abort_resp", resp_data, 8'h00);
        req_data[0 +: 8] = 8'h05;
        req = 4'b1001;
        tick();
        check("abort_noack", ack, 4'b0000);
        reset = 1'b1;
        tick();
        check("post_abort_grant", grant_id, 2'd0);
        check("post_abort_din", reg_data_in, 8'h05);
        tick();
        // Data change while WAIT must not reach the response
        req_data[0 +: 8] = 8'h99;
        tick();
        check("hold_ack", ack, 4'b0001);
        check("hold_resp", resp_data, 8'h06);
        req = 4'b1000;
        tick();
        tick();
        check("next_grant", grant_id, 2'd3);
        tick();
        tick();
        check("next_ack", ack, 4'b1000);
        check("next_resp", resp_data, 8'h78);
        req = 4'b0000;
        tick();

        // Withdrawal after grant
        req_data[16 +: 8] = 8'h30;
        req = 4'b0100;
        tick();
        check("wd_en", reg_enable, 1'b1);
        req = 4'b0000;
        tick();
        tick();
        check("wd_ack", ack, 4'b0100);
        check("wd_resp", resp_data, 8'h31);
        tick();
        check("wd_ack_off", ack, 4'b0000);
        check("wd_busy_off", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
